// File: rtl/fb_pkg.sv
// Shared constants, register map, state encoding and address helpers for the
// CPU-side framebuffer write port.
package fb_pkg;

    localparam int FB_COLS  = 100;
    localparam int FB_ROWS  = 75;
    localparam int FB_DEPTH = FB_COLS * FB_ROWS;
    localparam int FB_AW    = 13;

    localparam logic [2:0] REG_CURSOR_X = 3'd0;
    localparam logic [2:0] REG_CURSOR_Y = 3'd1;
    localparam logic [2:0] REG_DATA     = 3'd2;
    localparam logic [2:0] REG_CONTROL  = 3'd3;
    localparam logic [2:0] REG_STATUS   = 3'd4;

    localparam int STATUS_BUSY_BIT = 7;
    localparam int STATUS_ERR_BIT  = 6;

    localparam logic [6:0]       X_MAX     = 7'd99;
    localparam logic [6:0]       Y_MAX     = 7'd74;
    localparam logic [FB_AW-1:0] ADDR_LAST = 13'd7499;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2
    } fb_state_e;

    // y*100 + x built from shifts: 100 = 64 + 32 + 4
    function automatic logic [FB_AW-1:0] fb_lin_addr(input logic [6:0] y, input logic [6:0] x);
        logic [FB_AW-1:0] y_ext;
        y_ext = {6'd0, y};
        return (y_ext << 6) + (y_ext << 5) + (y_ext << 2) + {6'd0, x};
    endfunction

    function automatic logic [6:0] sat_coord(input logic [7:0] v, input logic [6:0] lim);
        if (v > {1'b0, lim}) begin
            return lim;
        end else begin
            return v[6:0];
        end
    endfunction

endpackage

// File: rtl/fb_bus_writer_if.sv
// CPU bus and framebuffer write signals of the tile framebuffer writer.
interface fb_bus_writer_if;

    logic                     bus_cs;
    logic                     bus_we;
    logic [2:0]               bus_addr;
    logic [7:0]               bus_data_in;
    logic [7:0]               bus_data_out;
    logic                     fb_we;
    logic [fb_pkg::FB_AW-1:0] fb_addr;
    logic [1:0]               fb_data;

    modport master (
        output bus_cs, bus_we, bus_addr, bus_data_in,
        input  bus_data_out, fb_we, fb_addr, fb_data
    );

    modport slave (
        input  bus_cs, bus_we, bus_addr, bus_data_in,
        output bus_data_out, fb_we, fb_addr, fb_data
    );

endinterface

// File: rtl/bus_strobe_sync.sv
// Brings the asynchronous CPU chip-select/write-enable into the pixel domain and
// emits a single-cycle strobe per CPU write access.
module bus_strobe_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_cs,
    input  logic i_we,
    output logic o_strobe
);

    logic [1:0] r_cs_sync;
    logic [1:0] r_we_sync;
    logic       r_acc_prev;
    logic       w_acc;

    assign w_acc = r_cs_sync[1] & r_we_sync[1];

    // two-flop synchronisers plus history flop for edge detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cs_sync  <= 2'b00;
            r_we_sync  <= 2'b00;
            r_acc_prev <= 1'b0;
        end else begin
            r_cs_sync  <= {r_cs_sync[0], i_cs};
            r_we_sync  <= {r_we_sync[0], i_we};
            r_acc_prev <= w_acc;
        end
    end

    // a long CS assertion still produces only one strobe
    assign o_strobe = w_acc & ~r_acc_prev;

endmodule

// File: rtl/fb_bus_writer.sv
// Register window, auto-advancing tile cursor and clear engine that write
// 2-bit tile indices into the 100x75 framebuffer.
module fb_bus_writer
    import fb_pkg::*;
(
    input  logic           i_clk_pixel,
    input  logic           i_reset_n,
    fb_bus_writer_if.slave bus
);

    fb_state_e        r_state;
    fb_state_e        w_next_state;
    logic [6:0]       r_cur_x;
    logic [6:0]       r_cur_y;
    logic             r_err;
    logic             r_fb_we;
    logic [FB_AW-1:0] r_fb_addr;
    logic [1:0]       r_fb_data;

    logic [6:0]       w_cur_x_nxt;
    logic [6:0]       w_cur_y_nxt;
    logic             w_err_nxt;
    logic             w_err_set;
    logic             w_fb_we_nxt;
    logic [FB_AW-1:0] w_fb_addr_nxt;
    logic [1:0]       w_fb_data_nxt;
    logic [7:0]       w_rd_data;

    logic w_strobe;
    logic w_wr_x;
    logic w_wr_y;
    logic w_wr_data;
    logic w_wr_ctrl;

    bus_strobe_sync u_strobe (
        .i_clk    (i_clk_pixel),
        .i_rst_n  (i_reset_n),
        .i_cs     (bus.bus_cs),
        .i_we     (bus.bus_we),
        .o_strobe (w_strobe)
    );

    assign w_wr_x    = w_strobe & (bus.bus_addr == REG_CURSOR_X);
    assign w_wr_y    = w_strobe & (bus.bus_addr == REG_CURSOR_Y);
    assign w_wr_data = w_strobe & (bus.bus_addr == REG_DATA);
    assign w_wr_ctrl = w_strobe & (bus.bus_addr == REG_CONTROL);

    // next state, cursor, error flag and framebuffer write port
    always_comb begin
        w_next_state  = r_state;
        w_fb_we_nxt   = 1'b0;
        w_fb_addr_nxt = r_fb_addr;
        w_fb_data_nxt = r_fb_data;
        w_err_set     = 1'b0;
        w_cur_x_nxt   = r_cur_x;
        w_cur_y_nxt   = r_cur_y;

        if (w_wr_x) begin
            w_cur_x_nxt = sat_coord(bus.bus_data_in, X_MAX);
        end else begin
            w_cur_x_nxt = r_cur_x;
        end
        if (w_wr_y) begin
            w_cur_y_nxt = sat_coord(bus.bus_data_in, Y_MAX);
        end else begin
            w_cur_y_nxt = r_cur_y;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_wr_data) begin
                    w_next_state  = ST_WRITE;
                    w_fb_we_nxt   = 1'b1;
                    w_fb_addr_nxt = fb_lin_addr(r_cur_y, r_cur_x);
                    w_fb_data_nxt = bus.bus_data_in[1:0];
                end else if (w_wr_ctrl && bus.bus_data_in[0]) begin
                    w_next_state  = ST_CLEAR;
                    w_fb_we_nxt   = 1'b1;
                    w_fb_addr_nxt = '0;
                    w_fb_data_nxt = bus.bus_data_in[2:1];
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WRITE: begin
                w_next_state = ST_IDLE;
                if (r_cur_x == X_MAX) begin
                    w_cur_x_nxt = 7'd0;
                    if (r_cur_y == Y_MAX) begin
                        w_cur_y_nxt = 7'd0;
                    end else begin
                        w_cur_y_nxt = r_cur_y + 7'd1;
                    end
                end else begin
                    w_cur_x_nxt = r_cur_x + 7'd1;
                end
            end
            ST_CLEAR: begin
                // fill value stays parked on r_fb_data for the whole sweep
                if (r_fb_addr == ADDR_LAST) begin
                    w_next_state = ST_IDLE;
                    w_cur_x_nxt  = 7'd0;
                    w_cur_y_nxt  = 7'd0;
                end else begin
                    w_fb_we_nxt   = 1'b1;
                    w_fb_addr_nxt = r_fb_addr + 13'd1;
                end
                if (w_wr_data) begin
                    w_err_set = 1'b1;
                end else begin
                    w_err_set = 1'b0;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        if (w_err_set) begin
            w_err_nxt = 1'b1;
        end else if (w_wr_ctrl && bus.bus_data_in[3]) begin
            w_err_nxt = 1'b0;
        end else begin
            w_err_nxt = r_err;
        end
    end

    // state register
    always_ff @(posedge i_clk_pixel or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // cursor, error flag and registered framebuffer outputs
    always_ff @(posedge i_clk_pixel or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cur_x   <= 7'd0;
            r_cur_y   <= 7'd0;
            r_err     <= 1'b0;
            r_fb_we   <= 1'b0;
            r_fb_addr <= '0;
            r_fb_data <= 2'd0;
        end else begin
            r_cur_x   <= w_cur_x_nxt;
            r_cur_y   <= w_cur_y_nxt;
            r_err     <= w_err_nxt;
            r_fb_we   <= w_fb_we_nxt;
            r_fb_addr <= w_fb_addr_nxt;
            r_fb_data <= w_fb_data_nxt;
        end
    end

    // CPU read mux
    always_comb begin
        w_rd_data = 8'd0;
        case (bus.bus_addr)
            REG_CURSOR_X: w_rd_data = {1'b0, r_cur_x};
            REG_CURSOR_Y: w_rd_data = {1'b0, r_cur_y};
            REG_STATUS: begin
                w_rd_data[STATUS_BUSY_BIT] = (r_state == ST_CLEAR);
                w_rd_data[STATUS_ERR_BIT]  = r_err;
            end
            default: w_rd_data = 8'd0;
        endcase
    end

    assign bus.bus_data_out = w_rd_data;
    assign bus.fb_we        = r_fb_we;
    assign bus.fb_addr      = r_fb_addr;
    assign bus.fb_data      = r_fb_data;

endmodule

// File: tb/tb_fb_bus_writer.sv
// Randomised self-checking bench for fb_bus_writer against a cursor/framebuffer model.
module tb_fb_bus_writer;
    import fb_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fb_bus_writer_if bus_if ();

    fb_bus_writer dut (
        .i_clk_pixel (clk),
        .i_reset_n   (rst_n),
        .bus         (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    int  n_checks = 0;
    int  n_pass   = 0;
    int  cyc      = 0;
    int  last_busy_cyc = -1;
    wr_t wr_q[$];
    int  m_x = 0;
    int  m_y = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // log every framebuffer write and the latest cycle BUSY was seen high
    always @(negedge clk) begin
        if (bus_if.fb_we === 1'b1)
            wr_q.push_back('{cyc, int'(bus_if.fb_addr), int'(bus_if.fb_data)});
        if (bus_if.bus_addr == 3'd4 && bus_if.bus_data_out[7] === 1'b1)
            last_busy_cyc = cyc;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cpu_write(input int a, input int d, input int hold);
        @(negedge clk);
        bus_if.bus_addr    = 3'(a);
        bus_if.bus_data_in = 8'(d);
        bus_if.bus_cs      = 1'b1;
        bus_if.bus_we      = 1'b1;
        repeat (hold) @(negedge clk);
        bus_if.bus_cs = 1'b0;
        bus_if.bus_we = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cpu_read(input int a, output int v);
        @(negedge clk);
        bus_if.bus_addr = 3'(a);
        #1;
        v = int'(bus_if.bus_data_out);
    endtask

    task automatic set_x(input int v);
        cpu_write(0, v, 4);
        m_x = (v > 99) ? 99 : v;
    endtask

    task automatic set_y(input int v);
        cpu_write(1, v, 4);
        m_y = (v > 74) ? 74 : v;
    endtask

    task automatic check_cursor(input string tag);
        int v;
        cpu_read(0, v);
        check({tag, "_x"}, v, m_x);
        cpu_read(1, v);
        check({tag, "_y"}, v, m_y);
    endtask

    task automatic data_write(input string tag, input int d, input int hold);
        int exp_addr;
        exp_addr = m_y * FB_COLS + m_x;
        wr_q.delete();
        cpu_write(2, d, hold);
        check({tag, "_nwe"}, wr_q.size(), 1);
        if (wr_q.size() > 0) begin
            check({tag, "_addr"}, wr_q[0].addr, exp_addr);
            check({tag, "_data"}, wr_q[0].data, d % 4);
        end
        m_x = m_x + 1;
        if (m_x == FB_COLS) begin
            m_x = 0;
            m_y = (m_y + 1) % FB_ROWS;
        end
    endtask

    initial begin
        int v;
        int bad;
        bit hit;
        int n_before;
        bus_if.bus_cs      = 1'b0;
        bus_if.bus_we      = 1'b0;
        bus_if.bus_addr    = 3'd0;
        bus_if.bus_data_in = 8'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        check_cursor("rst");
        cpu_read(4, v); check("rst_status", v, 0);
        for (int a = 2; a < 8; a++) begin
            if (a != 3 && a != 4) begin
                cpu_read(a, v); check($sformatf("rd0_reg%0d", a), v, 0);
            end
        end
        check("rst_no_we", wr_q.size(), 0);

        set_x(5); set_y(3);
        data_write("w305", 2, 4);
        check_cursor("adv");

        set_x(99); set_y(74);
        data_write("wlast", 1, 4);
        check_cursor("wrap_all");
        set_x(99); set_y(10);
        data_write("wrow", 3, 4);
        check_cursor("wrap_row");

        set_x(200); set_y(90);
        check_cursor("sat");

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: set_x(int'($urandom_range(0, 127)));
                1: set_y(int'($urandom_range(0, 127)));
                default: data_write("rnd", int'($urandom_range(0, 255)), 4);
            endcase
            check_cursor("rnd");
        end

        data_write("longcs", 1, 40);

        // full clear with fill 2 and a DATA write dropped in the middle
        wr_q.delete();
        last_busy_cyc = -1;
        cpu_write(3, 8'h05, 4);
        repeat (100) @(negedge clk);
        cpu_write(2, 3, 4);
        cpu_read(4, v); check("clr_status_mid", v, 8'hC0);
        hit = 1'b0;
        for (int i = 0; i < 9000 && !hit; i++) begin
            @(negedge clk); #1;
            if (wr_q.size() >= FB_DEPTH) hit = 1'b1;
        end
        repeat (10) @(negedge clk);
        check("clr_nwe", wr_q.size(), FB_DEPTH);
        bad = 0;
        for (int i = 0; i < wr_q.size(); i++) begin
            if (wr_q[i].addr != i || wr_q[i].data != 2 || wr_q[i].cyc != wr_q[0].cyc + i)
                bad++;
        end
        check("clr_seq_bad", bad, 0);
        if (wr_q.size() > 0)
            check("clr_busy_end", last_busy_cyc, wr_q[wr_q.size() - 1].cyc);
        cpu_read(4, v); check("clr_status_after", v, 8'h40);
        m_x = 0; m_y = 0;
        check_cursor("clr_cur");
        cpu_write(3, 8'h08, 4);
        cpu_read(4, v); check("err_clr", v, 0);

        // reset in the middle of a clear
        set_x(7); set_y(9);
        wr_q.delete();
        cpu_write(3, 8'h03, 4);
        hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            @(negedge clk); #1;
            if (wr_q.size() > 0 && wr_q[wr_q.size() - 1].addr >= 1000) hit = 1'b1;
        end
        check("rstclr_reached", int'(hit), 1);
        if (wr_q.size() > 0) check("rstclr_addr", wr_q[wr_q.size() - 1].addr, 1000);
        rst_n = 1'b0;
        bus_if.bus_addr = 3'd4;
        #1;
        check("rstclr_we", int'(bus_if.fb_we), 0);
        check("rstclr_busy", int'(bus_if.bus_data_out), 0);
        n_before = wr_q.size();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rstclr_no_more_we", wr_q.size(), n_before);
        m_x = 0; m_y = 0;
        check_cursor("rstclr_cur");
        cpu_read(4, v); check("rstclr_status", v, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fb_bus_writer.md
# fb_bus_writer

CPU-side write port for the tile framebuffer scanned out by the VGA GPU. Decodes 6502 bus accesses to a small register window, maintains an auto-advancing tile cursor, and issues single-cycle writes into the 100×75 framebuffer of 2-bit tile indices. A hardware clear engine fills the whole framebuffer without CPU involvement. The block runs entirely in the pixel clock domain; the GPU read side consumes the same framebuffer RAM.

## Interface
- FB_COLS, 100, tiles per row
- FB_ROWS, 75, tile rows
- FB_DEPTH, 7500, FB_COLS*FB_ROWS entries
- CLK_PIXEL  in  1  pixel clock; all logic on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- BUS_CS  in  1  register window select from CPU address decode; asynchronous to CLK_PIXEL
- BUS_WE  in  1  CPU write (inverted R/W); asynchronous
- BUS_ADDR  in  3  register select; stable while BUS_CS high
- BUS_DATA_IN  in  8  CPU write data; stable while BUS_CS & BUS_WE high
- BUS_DATA_OUT  out  8  read data, combinational mux of registers by BUS_ADDR
- FB_WE  out  1  framebuffer write strobe, one cycle per write
- FB_ADDR  out  13  linear address y*100 + x
- FB_DATA  out  2  tile index to write

## Operation
- Registers: 0 CURSOR_X (R/W, 0..99), 1 CURSOR_Y (R/W, 0..74), 2 DATA (W: tile index in bits[1:0]), 3 CONTROL (W: bit0 start clear, bits[2:1] fill value, bit3 clear ERR), 4 STATUS (R: bit7 BUSY, bit6 ERR, others 0). Reads of 2, 5–7 return 0x00.
- Cursor writes ≥ limit saturate: X→99, Y→74.
- DATA write: FB_ADDR = Y*100+X (computed as (Y<<6)+(Y<<5)+(Y<<2)+X, 13-bit), FB_DATA = bits[1:0], FB_WE pulse; then X+1; X=99 wraps to 0 with Y+1; Y=74 with X=99 wraps both to 0.
- States: IDLE, WRITE, CLEAR. IDLE→WRITE on DATA write strobe; WRITE→IDLE after one cycle. IDLE→CLEAR on CONTROL write with bit0=1; CLEAR issues FB_WE at addresses 0..7499, one per cycle, FB_DATA = fill value, then →IDLE; cursor reset to (0,0) on completion.
- BUSY = (state == CLEAR).
- During CLEAR: DATA writes dropped and ERR set; CONTROL start ignored; CONTROL bit3 and cursor writes still honoured.
- ERR sticky until CONTROL write with bit3=1. Set and clear in same cycle: set wins.
- Reset values: all outputs 0, cursor (0,0), state IDLE, ERR 0. Reset mid-CLEAR aborts immediately; framebuffer left partially filled, FB_WE low.

## Timing
- BUS_CS, BUS_WE: two-flop synchroniser; write strobe = rising edge of synced (CS & WE), one cycle, once per CPU access regardless of CS duration.
- BUS_ADDR/BUS_DATA_IN sampled in the strobe cycle.
- Cursor/CONTROL registers update on the cycle after strobe (strobe at cycle n → visible n+1).
- DATA write: FB_WE high exactly at cycle n+1 with address/data of pre-advance cursor; cursor advanced value visible at n+2.
- CLEAR: first FB_WE at n+1, last at n+7500; BUSY high n+1..n+7500, low n+7501.
- Back-to-back CPU writes are ≥ 1 µs apart; no queueing required.
- BUS_DATA_OUT purely combinational, valid while BUS_ADDR stable.

## Structure
- Shared package fb_pkg: FB_COLS, FB_ROWS, FB_DEPTH, register address constants, STATUS bit positions, state enum.
- Sub-module bus_strobe_sync: two-flop synchroniser plus rising-edge detector, producing the one-cycle write strobe.
- Address multiply by shift-add only; no multiplier inference.

## Test plan
- Reset then read all registers -> CURSOR_X=0, CURSOR_Y=0, STATUS=0x00, FB_WE never high.
- Write X=5, Y=3, DATA=2 -> one FB_WE with FB_ADDR=305, FB_DATA=2; CURSOR_X reads 6.
- Cursor at (99,74), DATA=1 -> FB_ADDR=7499, cursor wraps to (0,0); at (99,10) -> (0,11).
- Write X=200, Y=90 -> read back 99, 74.
- CONTROL=0x05 -> 7500 consecutive FB_WE, addresses 0..7499, FB_DATA=2, BUSY high for 7500 cycles; DATA write mid-clear dropped, STATUS=0xC0, then 0x40 after, CONTROL=0x08 -> 0x00.
- BUS_CS held high 40 cycles on one DATA write -> exactly one FB_WE; RESET_N low at clear address 1000 -> FB_WE low immediately, BUSY 0.
